// File: rtl/jesd204_tx_pkg.sv
// jesd204_tx_pkg
// Shared constants and helpers for the JESD204 transmit LMFC slice.
//   - L/F code constants and clamping of out-of-range codes
//   - decode of the F code to octets per frame (Foct)
//   - clocks per multiframe = Foct * (K+1), range 1..128
//   - lmfc_cfg_t: the latched link configuration
package jesd204_tx_pkg;

   localparam int OCTETS_PER_CLK = 4;

   localparam logic [1:0] L_1 = 2'd0;
   localparam logic [1:0] L_2 = 2'd1;
   localparam logic [1:0] L_4 = 2'd2;

   localparam logic [2:0] F_1  = 3'd0;
   localparam logic [2:0] F_2  = 3'd1;
   localparam logic [2:0] F_4  = 3'd2;
   localparam logic [2:0] F_8  = 3'd3;
   localparam logic [2:0] F_16 = 3'd4;

   localparam logic [2:0] K_MAX = 3'd7;

   typedef struct packed {
      logic [1:0] l_code;
      logic [2:0] f_code;
      logic [2:0] k_code;
   } lmfc_cfg_t;

   // Code 3 has no lane count behind it; the nearest legal value is 4 lanes.
   function automatic logic [1:0] clamp_l(input logic [1:0] code);
      return (code > L_4) ? L_4 : code;
   endfunction

   function automatic logic [2:0] clamp_f(input logic [2:0] code);
      return (code > F_16) ? F_16 : code;
   endfunction

   function automatic logic [2:0] clamp_k(input logic [4:0] code);
      return (code > 5'd7) ? K_MAX : code[2:0];
   endfunction

   // Only called with an already clamped code, so the shift never exceeds 16.
   function automatic logic [4:0] foct_of(input logic [2:0] f_code);
      return 5'd1 << f_code;
   endfunction

   // Each clock carries 4 octets and a multiframe is 4*(K+1) frames of Foct
   // octets, so the factor of 4 cancels and the clock count is Foct*(K+1).
   function automatic logic [7:0] clocks_per_mf(input logic [2:0] f_code,
                                                input logic [2:0] k_code);
      logic [7:0] foct8;
      logic [7:0] frames8;
      foct8   = {3'b000, foct_of(f_code)};
      frames8 = {5'b00000, k_code} + 8'd1;
      return foct8 * frames8;
   endfunction

endpackage

// File: rtl/jesd204_tx_lmfc_if.sv
// jesd204_tx_lmfc_if
// Control and flag bundle of the LMFC generator.
//   master: drives EN, LOAD_SETUP, SYSREF, L, F, K; receives the flags
//   slave : the generator itself
//   MS/ME/FS/FE : per-octet-slot multiframe/frame start/end, bit 0 earliest
//   SYNCED      : counter aligned to SYSREF, flags meaningful
//   L_CFG       : latched (clamped) lane code for downstream consumers
interface jesd204_tx_lmfc_if;

   logic       EN;
   logic       LOAD_SETUP;
   logic       SYSREF;
   logic [1:0] L;
   logic [2:0] F;
   logic [4:0] K;
   logic [3:0] MS;
   logic [3:0] ME;
   logic [3:0] FS;
   logic [3:0] FE;
   logic       SYNCED;
   logic [1:0] L_CFG;

   modport master (
      output EN, LOAD_SETUP, SYSREF, L, F, K,
      input  MS, ME, FS, FE, SYNCED, L_CFG
   );

   modport slave (
      input  EN, LOAD_SETUP, SYSREF, L, F, K,
      output MS, ME, FS, FE, SYNCED, L_CFG
   );

endinterface

// File: rtl/jesd204_sysref_edge.sv
// jesd204_sysref_edge
// Registers SYSREF and produces a one-cycle pulse on its rising edge, so a
// SYSREF held high acts only once.
//   clk, rst : clock and synchronous active-high reset
//   sysref   : alignment reference, already synchronous to clk
//   rise     : high in the cycle where sysref=1 and the registered copy is 0
module jesd204_sysref_edge (
   input  logic clk,
   input  logic rst,
   input  logic sysref,
   output logic rise
);

   logic sysref_q;

   // History register keeps tracking SYSREF regardless of enable state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sysref_q <= 1'b0;
      end else begin
         sysref_q <= sysref;
      end
   end

   assign rise = sysref & ~sysref_q;

endmodule

// File: rtl/jesd204_tx_lmfc.sv
// jesd204_tx_lmfc
// Local multiframe clock generator for the JESD204 TX link layer, 4 octets
// per lane per clock. Latches L/F/K, aligns a multiframe counter to SYSREF
// rising edges and emits registered per-octet-slot framing flags.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : jesd204_tx_lmfc_if.slave (controls in, flags out)
module jesd204_tx_lmfc #(
   parameter int OCTETS_PER_CLK = 4
) (
   input logic               CLK,
   input logic               RST,
   jesd204_tx_lmfc_if.slave  bus
);

   import jesd204_tx_pkg::*;

   lmfc_cfg_t                   cfg;
   logic [6:0]                  cnt;
   logic [6:0]                  cnt_next;
   logic                        synced;
   logic                        synced_next;
   logic                        sysref_rise;
   logic                        flags_valid;
   logic [7:0]                  cpm;
   logic [4:0]                  foct;
   logic [9:0]                  octet_idx;
   logic [9:0]                  mf_last;
   logic [9:0]                  frame_mask;
   logic [OCTETS_PER_CLK-1:0]   ms_n, me_n, fs_n, fe_n;
   logic [OCTETS_PER_CLK-1:0]   ms_q, me_q, fs_q, fe_q;

   jesd204_sysref_edge u_sysref_edge (
      .clk    (CLK),
      .rst    (RST),
      .sysref (bus.SYSREF),
      .rise   (sysref_rise)
   );

   // Next counter/sync state, then flags derived from the next count so the
   // registered flags describe the word leaving in the following cycle.
   always_comb begin
      cnt_next    = cnt;
      synced_next = synced;
      flags_valid = 1'b0;
      octet_idx   = '0;
      ms_n        = '0;
      me_n        = '0;
      fs_n        = '0;
      fe_n        = '0;
      cpm         = clocks_per_mf(cfg.f_code, cfg.k_code);
      foct        = foct_of(cfg.f_code);
      mf_last     = 10'(cpm) * 10'(OCTETS_PER_CLK) - 10'd1;
      frame_mask  = 10'(foct) - 10'd1;

      // A config load always drops sync, even if SYSREF rises in the same cycle.
      if (bus.LOAD_SETUP || !bus.EN) begin
         cnt_next    = '0;
         synced_next = 1'b0;
      end else if (sysref_rise) begin
         cnt_next    = '0;
         synced_next = 1'b1;
         flags_valid = 1'b1;
      end else if (synced) begin
         cnt_next    = ({1'b0, cnt} == cpm - 8'd1) ? 7'd0 : cnt + 7'd1;
         flags_valid = 1'b1;
      end

      // Foct is a power of two, so mod Foct is a mask of the octet index.
      for (int i = 0; i < OCTETS_PER_CLK; i++) begin
         octet_idx = 10'(cnt_next) * 10'(OCTETS_PER_CLK) + 10'(i);
         ms_n[i]   = flags_valid && (octet_idx == 10'd0);
         me_n[i]   = flags_valid && (octet_idx == mf_last);
         fs_n[i]   = flags_valid && ((octet_idx & frame_mask) == 10'd0);
         fe_n[i]   = flags_valid && ((octet_idx & frame_mask) == frame_mask);
      end
   end

   // State and output registers; config is latched with invalid codes clamped.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cfg    <= '0;
         cnt    <= '0;
         synced <= 1'b0;
         ms_q   <= '0;
         me_q   <= '0;
         fs_q   <= '0;
         fe_q   <= '0;
      end else begin
         if (bus.LOAD_SETUP) begin
            cfg.l_code <= clamp_l(bus.L);
            cfg.f_code <= clamp_f(bus.F);
            cfg.k_code <= clamp_k(bus.K);
         end
         cnt    <= cnt_next;
         synced <= synced_next;
         ms_q   <= ms_n;
         me_q   <= me_n;
         fs_q   <= fs_n;
         fe_q   <= fe_n;
      end
   end

   assign bus.MS     = ms_q;
   assign bus.ME     = me_q;
   assign bus.FS     = fs_q;
   assign bus.FE     = fe_q;
   assign bus.SYNCED = synced;
   assign bus.L_CFG  = cfg.l_code;

endmodule

// File: tb/tb_jesd204_tx_lmfc.sv
// tb_jesd204_tx_lmfc
// Directed self-checking bench for the JESD204 TX LMFC generator.
// Inputs change 1 time unit after a rising edge; outputs are compared at
// that same point, i.e. they show what the preceding edge registered.
module tb_jesd204_tx_lmfc;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;

   jesd204_tx_lmfc_if bus ();

   jesd204_tx_lmfc #(.OCTETS_PER_CLK(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // {SYNCED, MS, ME, FS, FE}
   function automatic logic [16:0] obs();
      return {bus.SYNCED, bus.MS, bus.ME, bus.FS, bus.FE};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.EN = 1'b1;
      bus.LOAD_SETUP = 1'b0;
      bus.SYSREF = 1'b0;
      bus.L = 2'd0;
      bus.F = 3'd0;
      bus.K = 5'd0;
      tick();
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      tick();
      checks++;
      if (obs() !== 17'b0) begin
         errors++;
         $display("[TB] FAIL reset_state got %b exp %b", obs(), 17'b0);
      end
      RST = 1'b0;
      tick();
      checks++;
      if (obs() !== 17'b0) begin
         errors++;
         $display("[TB] FAIL reset_sysref_ignored got %b exp %b", obs(), 17'b0);
      end
      checks++;
      if (bus.L_CFG !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_lcfg got %0d exp 0", bus.L_CFG);
      end
   endtask

   task automatic test_f4_k1();
      logic [16:0] exp;
      int phase;
      bus.L = 2'd1;
      bus.F = 3'd2;
      bus.K = 5'd1;
      bus.LOAD_SETUP = 1'b1;
      tick();
      bus.LOAD_SETUP = 1'b0;
      checks++;
      if (obs() !== 17'b0 || bus.L_CFG !== 2'd1) begin
         errors++;
         $display("[TB] FAIL f4k1_load got %b lcfg %0d exp %b lcfg 1", obs(), bus.L_CFG, 17'b0);
      end
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      exp = {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b1000};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("[TB] FAIL f4k1_align got %b exp %b", obs(), exp);
      end
      for (int c = 1; c <= 16; c++) begin
         tick();
         phase = c % 8;
         exp = {1'b1, (phase == 0) ? 4'b0001 : 4'b0000,
                (phase == 7) ? 4'b1000 : 4'b0000, 4'b0001, 4'b1000};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("[TB] FAIL f4k1_cycle%0d got %b exp %b", c, obs(), exp);
         end
      end
   endtask

   // Starts at phase 0 of an 8-clock multiframe (F=2, K=1).
   task automatic test_realign();
      logic [16:0] exp;
      int phase;
      for (int c = 0; c < 3; c++) tick();
      bus.SYSREF = 1'b1;
      tick();
      exp = {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b1000};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("[TB] FAIL realign_zero got %b exp %b", obs(), exp);
      end
      for (int c = 1; c <= 8; c++) begin
         if (c == 5) bus.SYSREF = 1'b0;
         tick();
         phase = c % 8;
         exp = {1'b1, (phase == 0) ? 4'b0001 : 4'b0000,
                (phase == 7) ? 4'b1000 : 4'b0000, 4'b0001, 4'b1000};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("[TB] FAIL realign_held%0d got %b exp %b", c, obs(), exp);
         end
      end
      bus.SYSREF = 1'b0;
   endtask

   task automatic test_f1_k0();
      logic [16:0] exp;
      bus.F = 3'd0;
      bus.K = 5'd0;
      bus.LOAD_SETUP = 1'b1;
      tick();
      bus.LOAD_SETUP = 1'b0;
      checks++;
      if (obs() !== 17'b0) begin
         errors++;
         $display("[TB] FAIL f1k0_load_unsync got %b exp %b", obs(), 17'b0);
      end
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      exp = {1'b1, 4'b0001, 4'b1000, 4'b1111, 4'b1111};
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("[TB] FAIL f1k0_cycle%0d got %b exp %b", c, obs(), exp);
         end
      end
   endtask

   task automatic test_f2_k0();
      logic [16:0] exp;
      bus.F = 3'd1;
      bus.K = 5'd0;
      bus.LOAD_SETUP = 1'b1;
      tick();
      bus.LOAD_SETUP = 1'b0;
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) tick();
         exp = {1'b1, (c % 2 == 0) ? 4'b0001 : 4'b0000,
                (c % 2 == 1) ? 4'b1000 : 4'b0000, 4'b0101, 4'b1010};
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("[TB] FAIL f2k0_cycle%0d got %b exp %b", c, obs(), exp);
         end
      end
   endtask

   // Out-of-range codes: F=7 -> 16 octets, K=20 -> 7, 128 clocks per multiframe.
   task automatic test_clamp();
      logic [16:0] exp;
      bus.L = 2'd3;
      bus.F = 3'd7;
      bus.K = 5'd20;
      bus.LOAD_SETUP = 1'b1;
      tick();
      bus.LOAD_SETUP = 1'b0;
      checks++;
      if (bus.L_CFG !== 2'd2) begin
         errors++;
         $display("[TB] FAIL clamp_lcfg got %0d exp 2", bus.L_CFG);
      end
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      exp = {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("[TB] FAIL clamp_cnt0 got %b exp %b", obs(), exp);
      end
      for (int c = 1; c <= 128; c++) begin
         tick();
         if (c == 3 || c == 4 || c == 127 || c == 128) begin
            case (c)
               3:       exp = {1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
               4:       exp = {1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
               127:     exp = {1'b1, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
               default: exp = {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
            endcase
            checks++;
            if (obs() !== exp) begin
               errors++;
               $display("[TB] FAIL clamp_cycle%0d got %b exp %b", c, obs(), exp);
            end
         end
      end
   endtask

   task automatic test_en_drop();
      logic [16:0] sync0;
      sync0 = {1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b1000};
      bus.L = 2'd0;
      bus.F = 3'd2;
      bus.K = 5'd1;
      bus.LOAD_SETUP = 1'b1;
      tick();
      bus.LOAD_SETUP = 1'b0;
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      bus.EN = 1'b0;
      tick();
      checks++;
      if (obs() !== 17'b0) begin
         errors++;
         $display("[TB] FAIL en_drop got %b exp %b", obs(), 17'b0);
      end
      bus.EN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (obs() !== 17'b0) begin
            errors++;
            $display("[TB] FAIL en_reenable%0d got %b exp %b", c, obs(), 17'b0);
         end
      end
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      checks++;
      if (obs() !== sync0) begin
         errors++;
         $display("[TB] FAIL en_resync got %b exp %b", obs(), sync0);
      end
      tick();
      bus.LOAD_SETUP = 1'b1;
      bus.SYSREF = 1'b1;
      tick();
      bus.LOAD_SETUP = 1'b0;
      checks++;
      if (obs() !== 17'b0) begin
         errors++;
         $display("[TB] FAIL load_beats_sysref got %b exp %b", obs(), 17'b0);
      end
      tick();
      checks++;
      if (obs() !== 17'b0) begin
         errors++;
         $display("[TB] FAIL held_sysref_no_edge got %b exp %b", obs(), 17'b0);
      end
      bus.SYSREF = 1'b0;
      tick();
      bus.SYSREF = 1'b1;
      tick();
      bus.SYSREF = 1'b0;
      checks++;
      if (obs() !== sync0) begin
         errors++;
         $display("[TB] FAIL final_resync got %b exp %b", obs(), sync0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_f4_k1();
      test_realign();
      test_f1_k0();
      test_f2_k0();
      test_clamp();
      test_en_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jesd204_tx_lmfc.md
Name: jesd204_tx_lmfc

Overview:
- Local multiframe clock (LMFC) generator for the JESD204 transmit link layer.
- Datapath is 4 octets per lane per CLK cycle.
- Latches link configuration (L, F, K) and aligns an internal multiframe counter to SYSREF.
- Emits per-octet-slot flags for frame start/end and multiframe start/end. Framing, scrambling and ILAS logic use these flags.

Parameters:
- OCTETS_PER_CLK, 4, octets per lane per CLK. Fixed; only 4 is supported.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  block enable; low holds block idle and unsynced.
- LOAD_SETUP  in  1  one-cycle strobe; latches L/F/K.
- SYSREF  in  1  alignment reference, synchronous to CLK.
- L  in  2  lanes code: 0→1, 1→2, 2→4; 3 is invalid and treated as 2.
- F  in  3  octets per frame, code: 0→1, 1→2, 2→4, 3→8, 4→16; 5..7 treated as 4.
- K  in  5  frames per multiframe = 4*(K+1); K 0..7 valid, >7 treated as 7.
- MS  out  4  multiframe-start flag per octet slot.
- ME  out  4  multiframe-end flag per octet slot.
- FS  out  4  frame-start flag per octet slot.
- FE  out  4  frame-end flag per octet slot.
- SYNCED  out  1  LMFC aligned to SYSREF; flags valid.

Behaviour:
- Bit i of MS/ME/FS/FE refers to octet slot i of the current 4-octet word. Bit 0 is the earliest octet in time.
- Reset (RST=1 at clock edge) clears:
  - config registers (L, F, K codes all 0);
  - SYSREF history register;
  - counter;
  - SYNCED=0;
  - MS/ME/FS/FE=0.
- Config latch:
  - When LOAD_SETUP=1, the registers take L/F/K after the edge, with invalid codes clamped.
  - The same edge clears SYNCED and the counter. A new SYSREF edge is required to resync.
  - LOAD_SETUP has priority over SYSREF in the same cycle.
- Derived values:
  - Foct = 1<<Fcode.
  - Clocks per multiframe = Foct*(K+1), range 1..128.
  - Counter cnt is 7 bits and counts clocks within the multiframe.
- SYSREF detect:
  - sysref_q is the registered SYSREF.
  - A rising edge is SYSREF=1 && sysref_q=0.
  - Only rising edges act; a held-high SYSREF acts once.
- Alignment:
  - On a clock edge with EN=1 and a detected rising edge: cnt←0 and SYNCED←1.
  - The outputs registered at that same edge show the cnt=0 pattern, so MS=4'b0001 appears in the cycle right after the edge.
  - Later rising edges re-zero cnt the same way; SYNCED stays 1.
- Counting:
  - While SYNCED=1, EN=1 and no alignment event, cnt increments each cycle.
  - cnt wraps to 0 after reaching clocks-per-multiframe−1.
- Flag generation (registered, computed from the next cnt value):
  - Octet index o_i = 4*cnt + i.
  - MS[i] = (o_i == 0).
  - ME[i] = (o_i == 4*Foct*(K+1) − 1).
  - FS[i] = (o_i mod Foct == 0).
  - FE[i] = (o_i mod Foct == Foct−1).
- EN=0 at any edge: SYNCED←0, cnt←0, all flags←0. sysref_q still tracks SYSREF.
- While SYNCED=0, all flags are 0.
- L is stored only, for downstream consumers. It does not affect counting.

Decomposition:
- Package jesd204_tx_pkg holds:
  - code constants (L_1/L_2/L_4, F_1..F_16);
  - function to decode Fcode to Foct;
  - function for clocks per multiframe;
  - OCTETS_PER_CLK.
- One sub-module, jesd204_sysref_edge: registers SYSREF and outputs the one-cycle rising-edge pulse.

Test Plan:
- Reset: hold RST=1 for 3 cycles → SYNCED=0 and all flags 0; pulse SYSREF during reset → no effect.
- F=2 (4 octets), K=1 (8 frames), LOAD_SETUP pulse, EN=1, SYSREF 1-cycle pulse:
  - SYNCED=1 after that edge;
  - multiframe period 8 cycles;
  - cycle 0: MS=0001, FS=0001, FE=1000;
  - cycle 7: ME=1000;
  - cycles 1..6: MS=ME=0;
  - pattern repeats every 8 cycles.
- F=0, K=0:
  - period 1 cycle;
  - every cycle MS=0001, ME=1000, FS=FE=1111.
- F=1, K=0:
  - period 2;
  - FS=0101 and FE=1010 every cycle;
  - MS=0001 on even cycles, ME=1000 on odd cycles.
- Realign: second SYSREF pulse at cnt=3 of an 8-cycle multiframe → next cycle shows MS=0001 and SYNCED stays 1. SYSREF held high for 5 cycles → single alignment only.
- EN dropped mid-multiframe → next cycle SYNCED=0 and flags 0. Re-enable without SYSREF → stays 0. LOAD_SETUP while synced → SYNCED=0.
